prim_ram_1p_arb: RTL and testbench
==================================

# prim_ram_1p_arb

Round-robin arbiter and init sequencer that shares one single-port RAM port among `NumReq` hosts. Sits between the hosts and one port of the `prim_ram_2p` / `prim_xilinx_ram_1p` RAM primitives (1-cycle read latency). It grants at most one host per cycle and routes read data back with a per-host valid. Optionally, after reset it zero-fills the RAM before accepting any traffic.

## Interface
Parameters:
- `NumReq`, 4, number of hosts (2..16)
- `Width`, 32, data width
- `Depth`, 128, RAM words; any value ≥2, not necessarily a power of two
- `Aw`, `$clog2(Depth)`, address width (localparam, derived)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk_i`  in  1  sole clock
  - `rst_ni`  in  1  reset
- Host side:
  - `host_req_i`  in  NumReq  request per host
  - `host_write_i`  in  NumReq  1=write, 0=read
  - `host_addr_i`  in  NumReq*Aw  packed addresses; host i at `[i*Aw +: Aw]`
  - `host_wdata_i`  in  NumReq*Width  packed write data
  - `host_gnt_o`  out  NumReq  one-hot-or-zero grant
  - `host_rvalid_o`  out  NumReq  read data valid for host i
  - `host_rdata_o`  out  Width  shared read data, equal to `ram_rdata_i`
- RAM side:
  - `ram_req_o`  out  1  RAM request
  - `ram_write_o`  out  1  RAM write enable
  - `ram_addr_o`  out  Aw  RAM address
  - `ram_wdata_o`  out  Width  RAM write data
  - `ram_rdata_i`  in  Width  RAM read data, valid 1 cycle after a read request
- Status:
  - `init_done_o`  out  1  RAM ready for host traffic

## Operation
- FSM states: `Init` (zero-fill) and `Run`. Reset enters `Init` when the macro is defined, otherwise `Run`.
- `Init`:
  - Issue `ram_req_o=1`, `ram_write_o=1`, `ram_wdata_o=0`, `ram_addr_o=cnt`, where `cnt` runs from 0 and increments by one each cycle.
  - On the cycle with `cnt==Depth-1`, go to `Run`.
  - All `host_gnt_o` are 0 while in `Init`.
- `Run`:
  - Grant = first host with `host_req_i` set, searching from priority pointer `ptr` upward and wrapping `NumReq-1`→0.
  - Grant is combinational, same cycle as the request.
  - The RAM outputs mux the granted host's write/addr/wdata; `ram_req_o` = any grant.
- Pointer update: on a grant to host g, `ptr` ← (g+1) mod `NumReq` at the next edge. With no grant, `ptr` holds.
- Hosts keep req/write/addr/wdata stable until granted. The arbiter does not register requests.
- Read response: registered one-hot `rd_owner` ← granted host when the grant is a read, else 0. `host_rvalid_o = rd_owner`.
- Writes produce no rvalid.
- With no requests: `ram_req_o=0`; `ram_addr_o`/`ram_wdata_o` are don't-care but held at 0.

## Timing
- Reset values:
  - `host_gnt_o=0`, `host_rvalid_o=0`, `ram_req_o=0`, `ram_write_o=0`, `ram_addr_o=0`, `ram_wdata_o=0`.
  - `ptr=0`, `cnt=0`.
  - `init_done_o=0` with the macro, 1 without it.
- During reset, all outputs are forced to those values regardless of inputs.
- Init lasts exactly `Depth` cycles after reset release. `init_done_o` rises on the first `Run` cycle and stays high until the next reset.
- Read latency: grant in cycle N → `host_rvalid_o[g]` and valid `host_rdata_o` in cycle N+1.
- Back-to-back grants are allowed every cycle. Each read's rvalid pipelines independently (one per cycle max).
- Simultaneous requests: exactly one grant per cycle; the others wait.
- Fairness: with all hosts requesting continuously, each is granted once every `NumReq` cycles.
- Reset asserted mid-init: the zero-fill restarts from address 0 after release.
- Reset asserted mid-read: the pending rvalid is dropped.
- `cnt` is `Aw` bits wide. The transition to `Run` compares against `Depth-1`, so a non-power-of-two `Depth` never wraps.

## Configuration
- Macro: `PRIM_RAM_ARB_INIT_EN`.
- Defined: the `Init` state, `cnt`, and the zero-fill are present. `init_done_o` behaves as described above.
- Undefined: there is no `Init` state, the FSM stays in `Run`, `init_done_o` is constant 1 (including during reset), and hosts may be granted in the first cycle after reset.

## Test plan
- Init (macro defined, `Depth=128`): release reset → RAM sees 128 consecutive writes of 0 to addresses 0..127, `init_done_o` rises in cycle 128, and no grants occur before then.
- Single read: host 2 reads address 0x05 after an earlier write of 0xDEADBEEF → `host_gnt_o=4'b0100` in the same cycle; next cycle `host_rvalid_o=4'b0100` and `host_rdata_o=0xDEADBEEF`.
- Contention: all 4 hosts request continuously from `ptr=0` → grant order 0,1,2,3,0,…, one grant per cycle, `ram_req_o` high every cycle.
- Pointer wrap: only hosts 3 and 0 request, after a grant to host 3 → next grant goes to host 0, then host 3.
- Mixed read/write burst: host 1 writes 0x11 to address 7 in cycle N, then host 0 reads address 7 in cycle N+1 → `host_rvalid_o[0]` in N+2 with data 0x11; `host_rvalid_o[1]` is never set.
- Reset mid-init: assert `rst_ni` low at init address 40 → all outputs go to reset values immediately; after release the zero-fill restarts at address 0.

Source files
------------

// File: rtl/prim_ram_1p_arb.sv
// Round-robin arbiter sharing one single-port RAM port among NumReq hosts.
// Define PRIM_RAM_ARB_INIT_EN to zero-fill the RAM after reset.
module prim_ram_1p_arb #(
   parameter int NumReq = 4,
   parameter int Width  = 32,
   parameter int Depth  = 128,
   localparam int Aw    = $clog2(Depth)
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic [NumReq-1:0]       host_req_i,
   input  logic [NumReq-1:0]       host_write_i,
   input  logic [NumReq*Aw-1:0]    host_addr_i,
   input  logic [NumReq*Width-1:0] host_wdata_i,
   output logic [NumReq-1:0]       host_gnt_o,
   output logic [NumReq-1:0]       host_rvalid_o,
   output logic [Width-1:0]        host_rdata_o,
   output logic                    ram_req_o,
   output logic                    ram_write_o,
   output logic [Aw-1:0]           ram_addr_o,
   output logic [Width-1:0]        ram_wdata_o,
   input  logic [Width-1:0]        ram_rdata_i,
   output logic                    init_done_o
);

   localparam int Pw = $clog2(NumReq);

   logic              run;
   logic [Pw-1:0]     ptr_q;
   logic [Pw-1:0]     gidx;
   logic              found;
   logic [NumReq-1:0] gnt;
   logic [NumReq-1:0] rd_owner_q;
   int                idx;

`ifdef PRIM_RAM_ARB_INIT_EN
   typedef enum logic {Init, Run} state_e;

   state_e        state_q, state_d;
   logic [Aw-1:0] cnt_q, cnt_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= Init;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (state_q == Init) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == Aw'(Depth - 1)) begin
            state_d = Run;
            cnt_d   = '0;
         end
      end
   end

   assign run         = (state_q == Run);
   assign init_done_o = run;
`else
   assign run         = 1'b1;
   assign init_done_o = 1'b1;
`endif

   // Search upward from ptr_q, wrapping at NumReq-1.
   always_comb begin
      gnt   = '0;
      gidx  = '0;
      found = 1'b0;
      idx   = 0;
      for (int i = 0; i < NumReq; i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= NumReq) idx = idx - NumReq;
         if (!found && host_req_i[idx]) begin
            found = 1'b1;
            gidx  = Pw'(idx);
         end
      end
      if (rst_ni && run && found) gnt[gidx] = 1'b1;
   end

   assign host_gnt_o = gnt;

   always_comb begin
      ram_req_o   = 1'b0;
      ram_write_o = 1'b0;
      ram_addr_o  = '0;
      ram_wdata_o = '0;
`ifdef PRIM_RAM_ARB_INIT_EN
      if (rst_ni && !run) begin
         ram_req_o   = 1'b1;
         ram_write_o = 1'b1;
         ram_addr_o  = cnt_q;
      end
`endif
      if (|gnt) begin
         ram_req_o   = 1'b1;
         ram_write_o = host_write_i[gidx];
         ram_addr_o  = host_addr_i[int'(gidx)*Aw +: Aw];
         ram_wdata_o = host_wdata_i[int'(gidx)*Width +: Width];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         ptr_q      <= '0;
         rd_owner_q <= '0;
      end else begin
         rd_owner_q <= gnt & ~host_write_i;
         if (|gnt) begin
            ptr_q <= (gidx == Pw'(NumReq - 1)) ? '0 : gidx + 1'b1;
         end
      end
   end

   assign host_rvalid_o = rd_owner_q;
   assign host_rdata_o  = ram_rdata_i;

endmodule

// File: tb/tb_prim_ram_1p_arb.sv
// Directed bench for prim_ram_1p_arb with a 1-cycle-latency RAM model.
// Covers both PRIM_RAM_ARB_INIT_EN builds.
module tb_prim_ram_1p_arb;

   localparam int NumReq = 4;
   localparam int Width  = 32;
   localparam int Depth  = 128;
   localparam int Aw     = 7;

`ifdef PRIM_RAM_ARB_INIT_EN
   localparam logic        InitEn = 1'b1;
   localparam logic [31:0] Zf     = 32'h0;
`else
   localparam logic        InitEn = 1'b0;
   localparam logic [31:0] Zf     = 32'hA5A5_A5A5;
`endif

   logic                    clk = 1'b0;
   logic                    rst_ni;
   logic [NumReq-1:0]       host_req;
   logic [NumReq-1:0]       host_write;
   logic [NumReq*Aw-1:0]    host_addr;
   logic [NumReq*Width-1:0] host_wdata;
   logic [NumReq-1:0]       host_gnt;
   logic [NumReq-1:0]       host_rvalid;
   logic [Width-1:0]        host_rdata;
   logic                    ram_req;
   logic                    ram_write;
   logic [Aw-1:0]           ram_addr;
   logic [Width-1:0]        ram_wdata;
   logic [Width-1:0]        ram_rdata;
   logic                    init_done;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   prim_ram_1p_arb #(
      .NumReq(NumReq),
      .Width (Width),
      .Depth (Depth)
   ) dut (
      .clk_i        (clk),
      .rst_ni       (rst_ni),
      .host_req_i   (host_req),
      .host_write_i (host_write),
      .host_addr_i  (host_addr),
      .host_wdata_i (host_wdata),
      .host_gnt_o   (host_gnt),
      .host_rvalid_o(host_rvalid),
      .host_rdata_o (host_rdata),
      .ram_req_o    (ram_req),
      .ram_write_o  (ram_write),
      .ram_addr_o   (ram_addr),
      .ram_wdata_o  (ram_wdata),
      .ram_rdata_i  (ram_rdata),
      .init_done_o  (init_done)
   );

   logic [Width-1:0] mem [Depth];
   bit               mem_ready;

   // Pre-fill with a non-zero pattern so the zero-fill is observable.
   always @(posedge clk) begin
      if (!mem_ready) begin
         for (int i = 0; i < Depth; i++) mem[i] <= 32'hA5A5_A5A5;
         mem_ready <= 1'b1;
      end else if (ram_req) begin
         if (ram_write) mem[ram_addr] <= ram_wdata;
         else ram_rdata <= mem[ram_addr];
      end
   end

   task automatic chk(input string tag, input logic [63:0] got,
                      input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic next();
      @(posedge clk);
      #1;
   endtask

   task automatic set_host(input int i, input logic wr,
                           input logic [Aw-1:0] a,
                           input logic [Width-1:0] d);
      host_write[i]            = wr;
      host_addr[i*Aw +: Aw]    = a;
      host_wdata[i*Width +: Width] = d;
   endtask

   initial begin
      rst_ni     = 1'b0;
      host_req   = '1;
      host_write = '0;
      host_addr  = '0;
      host_wdata = '0;
      #7;
      chk("rst_gnt", 64'(host_gnt), 64'h0);
      chk("rst_rvalid", 64'(host_rvalid), 64'h0);
      chk("rst_ram_req", 64'(ram_req), 64'h0);
      chk("rst_ram_write", 64'(ram_write), 64'h0);
      chk("rst_ram_addr", 64'(ram_addr), 64'h0);
      chk("rst_ram_wdata", 64'(ram_wdata), 64'h0);
      chk("rst_init_done", 64'(init_done), 64'(!InitEn));

      next();
      rst_ni = 1'b1;
`ifdef PRIM_RAM_ARB_INIT_EN
      for (int c = 0; c < Depth; c++) begin
         @(negedge clk);
         chk("init_bus",
             64'({ram_req, ram_write, ram_addr, ram_wdata, host_gnt, init_done}),
             64'({1'b1, 1'b1, Aw'(c), 32'h0, 4'b0000, 1'b0}));
      end
`endif
      @(negedge clk);
      chk("first_gnt", 64'(host_gnt), 64'b0001);
      chk("first_done", 64'(init_done), 64'h1);
      next();
      host_req = '0;
      @(negedge clk);
      chk("first_rvalid", 64'(host_rvalid), 64'b0001);
      chk("zero_fill_rd", 64'(host_rdata), 64'(Zf));

      // ptr is 1: host 2 writes then reads address 5
      next();
      set_host(2, 1'b1, 7'h05, 32'hDEAD_BEEF);
      host_req = 4'b0100;
      @(negedge clk);
      chk("wr_gnt", 64'(host_gnt), 64'b0100);
      chk("wr_bus", 64'({ram_req, ram_write, ram_addr, ram_wdata}),
          64'({1'b1, 1'b1, 7'h05, 32'hDEAD_BEEF}));
      next();
      host_write[2] = 1'b0;
      @(negedge clk);
      chk("rd_gnt", 64'(host_gnt), 64'b0100);
      chk("rd_write", 64'(ram_write), 64'h0);
      chk("wr_no_rvalid", 64'(host_rvalid), 64'h0);
      next();
      host_req = '0;
      @(negedge clk);
      chk("rd_rvalid", 64'(host_rvalid), 64'b0100);
      chk("rd_rdata", 64'(host_rdata), 64'hDEAD_BEEF);
      chk("idle_bus", 64'({ram_req, ram_write, ram_addr, ram_wdata}), 64'h0);

      // ptr is 3: hosts 3 and 0 contend
      next();
      set_host(3, 1'b0, 7'h05, 32'h0);
      set_host(0, 1'b0, 7'h00, 32'h0);
      host_req = 4'b1001;
      @(negedge clk);
      chk("wrap_g3", 64'(host_gnt), 64'b1000);
      next();
      @(negedge clk);
      chk("wrap_g0", 64'(host_gnt), 64'b0001);
      chk("wrap_rv3", 64'(host_rvalid), 64'b1000);
      chk("wrap_rd3", 64'(host_rdata), 64'hDEAD_BEEF);
      next();
      @(negedge clk);
      chk("wrap_g3b", 64'(host_gnt), 64'b1000);
      chk("wrap_rv0", 64'(host_rvalid), 64'b0001);
      chk("wrap_rd0", 64'(host_rdata), 64'(Zf));
      next();
      host_req = '0;
      @(negedge clk);
      chk("wrap_rv3b", 64'(host_rvalid), 64'b1000);

      // ptr is 0: all hosts contend
      next();
      host_req = '1;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         chk("rr_gnt", 64'(host_gnt), 64'(4'b0001 << (k % 4)));
         chk("rr_req", 64'(ram_req), 64'h1);
         if (k > 0) chk("rr_rvalid", 64'(host_rvalid), 64'(4'b0001 << ((k - 1) % 4)));
         next();
      end
      host_req = '0;
      @(negedge clk);
      chk("rr_rvalid_last", 64'(host_rvalid), 64'b1000);

      // host 1 writes 0x11 to 7, host 0 reads it back
      next();
      set_host(1, 1'b1, 7'h07, 32'h11);
      host_req = 4'b0010;
      @(negedge clk);
      chk("mix_wr_gnt", 64'(host_gnt), 64'b0010);
      chk("mix_wr_bus", 64'({ram_write, ram_addr, ram_wdata}),
          64'({1'b1, 7'h07, 32'h11}));
      next();
      set_host(0, 1'b0, 7'h07, 32'h0);
      host_req = 4'b0001;
      @(negedge clk);
      chk("mix_rd_gnt", 64'(host_gnt), 64'b0001);
      chk("mix_rd_addr", 64'(ram_addr), 64'h07);
      chk("mix_no_rv", 64'(host_rvalid), 64'h0);
      next();
      host_req = '0;
      @(negedge clk);
      chk("mix_rvalid", 64'(host_rvalid), 64'b0001);
      chk("mix_rdata", 64'(host_rdata), 64'h11);

      // reset while a read response is pending
      next();
      host_req = 4'b0001;
      @(negedge clk);
      chk("mr_gnt", 64'(host_gnt), 64'b0001);
      next();
      host_req = '0;
      chk("mr_rvalid", 64'(host_rvalid), 64'b0001);
      rst_ni = 1'b0;
      #1;
      chk("mr_drop", 64'(host_rvalid), 64'h0);
      chk("mr_done", 64'(init_done), 64'(!InitEn));
      next();
      rst_ni = 1'b1;
      @(negedge clk);
      chk("mr_after_rv", 64'(host_rvalid), 64'h0);
      chk("mr_after_bus", 64'({ram_req, ram_addr}), 64'({InitEn, 7'h00}));

`ifdef PRIM_RAM_ARB_INIT_EN
      for (int c = 1; c <= 40; c++) begin
         @(negedge clk);
         chk("mi_addr", 64'(ram_addr), 64'(c));
      end
      #1;
      rst_ni = 1'b0;
      #1;
      chk("mi_rst_bus",
          64'({ram_req, ram_write, ram_addr, ram_wdata, host_gnt, host_rvalid, init_done}),
          64'h0);
      next();
      rst_ni = 1'b1;
      @(negedge clk);
      chk("mi_restart0", 64'({ram_req, ram_write, ram_addr, init_done}),
          64'({1'b1, 1'b1, 7'h00, 1'b0}));
      @(negedge clk);
      chk("mi_restart1", 64'(ram_addr), 64'h01);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
